dvp_pattern_tx: RTL



---
 rtl/dvp_pattern_tx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dvp_pattern_tx.sv
// Synthetic OV7725-style DVP source: vsync/href framing with an RGB565 byte stream
// built from one of four test patterns, high byte first, one byte per clock.
module dvp_pattern_tx #(
  parameter int          H_PIXEL   = 640,
  parameter int          V_PIXEL   = 480,
  parameter int          H_BLANK   = 144,
  parameter int          VS_LINES  = 4,
  parameter int          VB_LINES  = 18,
  parameter int          VF_LINES  = 8,
  parameter logic [15:0] SOLID_RGB = 16'hF800
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] pattern_sel,
  output logic       cam_vsync,
  output logic       cam_href,
  output logic [7:0] cam_data,
  output logic       frame_done,
  output logic       busy
);

  localparam int LINE_LEN = 2 * H_PIXEL + H_BLANK;
  localparam int HW       = $clog2(LINE_LEN);
  localparam int VW       = 16;
  localparam int BAR_W    = H_PIXEL / 8;
  localparam int BW       = $clog2(BAR_W);

  localparam logic [HW-1:0] H_LAST   = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] HREF_END = HW'(2 * H_PIXEL);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [VW-1:0] last_line;
  logic [1:0]    pat_q;
  logic [15:0]   pix_cnt_q;
  logic [BW-1:0] bar_w_q;
  logic [2:0]    bar_idx_q;
  logic [15:0]   bar_rgb, pix;
  logic          href_d, frame_start;
  logic [7:0]    data_d;

  // Position (state, h, v) describes the cycle whose outputs are being registered.
  always_comb begin
    state_d   = state_q;
    h_d       = h_q + 1'b1;
    v_d       = v_q;
    last_line = '0;
    case (state_q)
      VSYNC:   last_line = VW'(VS_LINES - 1);
      VBACK:   last_line = VW'(VB_LINES - 1);
      ACTIVE:  last_line = VW'(V_PIXEL - 1);
      VFRONT:  last_line = VW'(VF_LINES - 1);
      default: last_line = '0;
    endcase
    if (state_q == IDLE) begin
      h_d = '0;
      v_d = '0;
      if (en) state_d = VSYNC;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == last_line) begin
        v_d = '0;
        case (state_q)
          VSYNC:   state_d = VBACK;
          VBACK:   state_d = ACTIVE;
          ACTIVE:  state_d = VFRONT;
          VFRONT:  state_d = en ? VSYNC : IDLE;
          default: state_d = IDLE;
        endcase
      end else begin
        v_d = v_q + 1'b1;
      end
    end
  end

  always_comb begin
    case (bar_idx_q)
      3'd0:    bar_rgb = 16'hFFFF;
      3'd1:    bar_rgb = 16'hFFE0;
      3'd2:    bar_rgb = 16'h07FF;
      3'd3:    bar_rgb = 16'h07E0;
      3'd4:    bar_rgb = 16'hF81F;
      3'd5:    bar_rgb = 16'hF800;
      3'd6:    bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
    case (pat_q)
      2'd0:    pix = bar_rgb;
      2'd1:    pix = SOLID_RGB;
      2'd2:    pix = pix_cnt_q;
      default: pix = (h_d[6] ^ v_d[5]) ? 16'h0000 : 16'hFFFF;
    endcase
    frame_start = (state_d == VSYNC) && (state_q != VSYNC);
    href_d      = (state_d == ACTIVE) && (h_d < HREF_END);
    data_d      = href_d ? (h_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      h_q        <= '0;
      v_q        <= '0;
      pat_q      <= '0;
      pix_cnt_q  <= '0;
      bar_w_q    <= '0;
      bar_idx_q  <= '0;
      cam_vsync  <= 1'b0;
      cam_href   <= 1'b0;
      cam_data   <= 8'h00;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      v_q        <= v_d;
      cam_vsync  <= (state_d == VSYNC);
      cam_href   <= href_d;
      cam_data   <= data_d;
      frame_done <= (state_d == VFRONT) && (v_d == VW'(VF_LINES - 1)) && (h_d == H_LAST);
      busy       <= (state_d != IDLE);
      if (frame_start) begin
        pat_q     <= pattern_sel;
        pix_cnt_q <= '0;
        bar_w_q   <= '0;
        bar_idx_q <= '0;
      end else if (href_d && h_d[0]) begin
        // Advance pattern state after the low byte; bars wrap to 0 exactly at line end.
        pix_cnt_q <= pix_cnt_q + 16'd1;
        if (bar_w_q == BAR_LAST) begin
          bar_w_q   <= '0;
          bar_idx_q <= bar_idx_q + 3'd1;
        end else begin
          bar_w_q <= bar_w_q + 1'b1;
        end
      end
    end
  end

endmodule
